// File: rtl/mem_exerciser.sv
// mem_exerciser: pattern write/read-back traffic generator and checker for the CPU memory port (start/modes in; addr/wr_data/we/byte_m out; rd_data/ready in; busy/done/pass/timeout/error report out)
module mem_exerciser #(
  parameter int         AW      = 20,
  parameter int         BASE    = 0,
  parameter int         LEN     = 1024,
  parameter logic [7:0] SEED    = 8'h5A,
  parameter int         TIMEOUT = 255
) (
  input  logic          cpu_clk,
  input  logic          rst,
  input  logic          start,
  input  logic          wr_align,
  input  logic [1:0]    rd_mode,
  output logic [AW-1:0] addr,
  output logic [15:0]   wr_data,
  output logic          we,
  output logic          byte_m,
  input  logic [15:0]   rd_data,
  input  logic          ready,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          timeout,
  output logic [7:0]    err_count,
  output logic [AW-1:0] err_addr,
  output logic [15:0]   err_exp,
  output logic [15:0]   err_got
);
  localparam int IW   = $clog2(LEN + 2);
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int HALF = LEN / 2;

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_B, S_RD_WE, S_RD_WO, S_DONE} state_t;

  state_t        r_state, w_nxt, w_rd0;
  logic [IW-1:0] r_idx;
  logic [TW-1:0] r_wait;
  logic [1:0]    r_mode;
  logic          r_align, r_to;
  logic [7:0]    r_cnt;
  logic [AW-1:0] r_eaddr;
  logic [15:0]   r_eexp, r_egot;
  logic [AW-1:0] w_off, w_addr;
  logic          w_req, w_wr, w_byte, w_last, w_acc, w_to, w_go, w_miss;
  logic [15:0]   w_exp, w_got;

  function automatic logic [7:0] pat(input logic [AW-1:0] a);
    logic [15:0] x;
    x = 16'(a);
    return x[7:0] ^ x[15:8] ^ SEED;
  endfunction

  always_comb begin
    w_off  = '0;
    w_byte = 1'b0;
    w_last = 1'b0;
    w_req  = 1'b1;
    w_wr   = 1'b0;
    case (r_state)
      S_WR: begin
        w_wr   = 1'b1;
        w_off  = r_align && r_idx != '0 ? (AW'(r_idx) << 1) - AW'(1) : AW'(r_idx) << 1;
        w_byte = r_align && (r_idx == '0 || r_idx == IW'(HALF));
        w_last = r_idx == IW'(r_align ? HALF : HALF - 1);
      end
      S_RD_B: begin
        w_off  = AW'(r_idx);
        w_byte = 1'b1;
        w_last = r_idx == IW'(LEN - 1);
      end
      S_RD_WE: begin
        w_off  = AW'(r_idx) << 1;
        w_last = r_idx == IW'(HALF - 1);
      end
      S_RD_WO: begin
        w_off  = (AW'(r_idx) << 1) + AW'(1);
        w_last = r_idx == IW'(HALF - 2);
      end
      default: w_req = 1'b0;
    endcase
    w_addr = w_req ? AW'(BASE) + w_off : '0;
    w_exp  = w_byte ? {8'h00, pat(w_addr)} : {pat(w_addr + AW'(1)), pat(w_addr)};
    w_got  = w_byte ? {8'h00, rd_data[7:0]} : rd_data;
    w_acc  = w_req && ready;
    w_to   = w_req && !ready && r_wait == TW'(TIMEOUT - 1);
    w_go   = start && !w_req;
    w_miss = w_acc && !w_wr && w_got != w_exp;
    w_rd0  = r_mode == 2'd2 ? S_RD_WO : r_mode == 2'd1 ? S_RD_WE : S_RD_B;
    w_nxt  = w_go ? S_WR :
             w_to ? S_DONE :
             !(w_acc && w_last) ? r_state :
             r_state == S_WR ? w_rd0 :
             r_mode != 2'd3 || r_state == S_RD_WO ? S_DONE :
             r_state == S_RD_B ? S_RD_WE : S_RD_WO;
  end

  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_wait  <= '0;
      r_mode  <= '0;
      r_align <= 1'b0;
      r_to    <= 1'b0;
      r_cnt   <= '0;
      r_eaddr <= '0;
      r_eexp  <= '0;
      r_egot  <= '0;
    end else begin
      r_state <= w_nxt;
      r_wait  <= w_req && !ready ? r_wait + TW'(1) : '0;
      if (w_acc) r_idx <= w_last ? '0 : r_idx + IW'(1);
      if (w_to) r_to <= 1'b1;
      if (w_miss) begin
        if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
        if (r_cnt == 8'h00) begin
          r_eaddr <= w_addr;
          r_eexp  <= w_exp;
          r_egot  <= w_got;
        end
      end
      if (w_go) begin
        r_mode  <= rd_mode;
        r_align <= wr_align;
        r_idx   <= '0;
        r_to    <= 1'b0;
        r_cnt   <= '0;
        r_eaddr <= '0;
        r_eexp  <= '0;
        r_egot  <= '0;
      end
    end
  end

  assign addr      = w_addr;
  assign wr_data   = w_wr ? w_exp : '0;
  assign we        = !w_wr;
  assign byte_m    = w_byte;
  assign busy      = w_req;
  assign done      = r_state == S_DONE;
  assign pass      = done && r_cnt == 8'h00 && !r_to;
  assign timeout   = r_to;
  assign err_count = r_cnt;
  assign err_addr  = r_eaddr;
  assign err_exp   = r_eexp;
  assign err_got   = r_egot;
endmodule

// File: tb/tb_mem_exerciser.sv
// tb_mem_exerciser: directed bench for mem_exerciser with two instances (small window at 0, 1K window straddling 0x400)
module tb_mem_exerciser;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        rst, start0, start1, wra0, wra1, ready0, ready1, c13, stuck1;
  logic [1:0]  rdm0, rdm1, r3 = 2'd0;
  logic [19:0] addr0, addr1, eaddr0, eaddr1;
  logic [15:0] wr0, wr1, rd0, rd1, eexp0, eexp1, egot0, egot1;
  logic        we0, we1, byte0, byte1, busy0, busy1, done0, done1, pass0, pass1, to0, to1;
  logic [7:0]  errc0, errc1;
  logic [7:0]  mem0 [0:4095];
  logic [7:0]  mem1 [0:4095];

  int aw1 = 0, ar1 = 0, stab_err = 0;
  logic        prev_pend = 1'b0;
  logic [37:0] prev_req = '0;

  mem_exerciser #(.AW(20), .BASE(0), .LEN(32), .SEED(8'h5A), .TIMEOUT(255)) u0 (
    .cpu_clk(clk), .rst(rst), .start(start0), .wr_align(wra0), .rd_mode(rdm0),
    .addr(addr0), .wr_data(wr0), .we(we0), .byte_m(byte0), .rd_data(rd0), .ready(ready0),
    .busy(busy0), .done(done0), .pass(pass0), .timeout(to0), .err_count(errc0),
    .err_addr(eaddr0), .err_exp(eexp0), .err_got(egot0));

  mem_exerciser #(.AW(20), .BASE(20'h003F8), .LEN(1024), .SEED(8'h5A), .TIMEOUT(255)) u1 (
    .cpu_clk(clk), .rst(rst), .start(start1), .wr_align(wra1), .rd_mode(rdm1),
    .addr(addr1), .wr_data(wr1), .we(we1), .byte_m(byte1), .rd_data(rd1), .ready(ready1),
    .busy(busy1), .done(done1), .pass(pass1), .timeout(to1), .err_count(errc1),
    .err_addr(eaddr1), .err_exp(eexp1), .err_got(egot1));

  always @(posedge clk) r3 <= r3 == 2'd2 ? 2'd0 : r3 + 2'd1;
  assign ready1 = r3 == 2'd2;

  always @(posedge clk) begin
    if (ready0 && !we0) begin
      mem0[addr0[11:0]] <= wr0[7:0];
      if (!byte0) mem0[addr0[11:0] + 12'd1] <= wr0[15:8];
    end
    if (ready1 && !we1) begin
      mem1[addr1[11:0]] <= wr1[7:0];
      if (!byte1) mem1[addr1[11:0] + 12'd1] <= wr1[15:8];
    end
  end

  assign rd0 = {c13 && addr0 == 20'h00012 ? 8'h00 : mem0[addr0[11:0] + 12'd1],
                c13 && addr0 == 20'h00013 ? 8'h00 : mem0[addr0[11:0]]};
  assign rd1 = stuck1 ? 16'h0000 : {mem1[addr1[11:0] + 12'd1], mem1[addr1[11:0]]};

  always @(negedge clk) begin
    if (busy1 && ready1) begin
      if (!we1) aw1++;
      else ar1++;
    end
    if (prev_pend && busy1 && {addr1, wr1, we1, byte1} != prev_req) stab_err++;
    prev_pend = busy1 && !ready1;
    prev_req  = {addr1, wr1, we1, byte1};
  end

  task automatic run0(input int poke, output int nw, output int nr, output bit fin);
    nw = 0; nr = 0; fin = 1'b0;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (i == poke) begin start0 = 1'b1; wra0 = ~wra0; rdm0 = ~rdm0; end
      if (i == poke + 1) start0 = 1'b0;
      if (busy0 && ready0) begin
        if (!we0) nw++;
        else nr++;
      end
      if (done0) begin fin = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_done1(output bit fin);
    fin = 1'b0;
    for (int i = 0; i < 20000 && !fin; i++) begin
      @(negedge clk);
      fin = done1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start0 = 1'b1; start1 = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({busy0, done0, pass0, to0, we0, byte0} !== 6'b000010) begin errors++; $display("FAIL reset_flags0 got %b exp 000010", {busy0, done0, pass0, to0, we0, byte0}); end
    checks++; if ({addr0, wr0, errc0, eaddr0, eexp0, egot0} !== '0) begin errors++; $display("FAIL reset_data0 got %h exp 0", {addr0, wr0, errc0, eaddr0, eexp0, egot0}); end
    checks++; if ({busy1, done1, pass1, to1, we1, byte1} !== 6'b000010) begin errors++; $display("FAIL reset_flags1 got %b exp 000010", {busy1, done1, pass1, to1, we1, byte1}); end
    checks++; if ({addr1, wr1, errc1, eaddr1, eexp1, egot1} !== '0) begin errors++; $display("FAIL reset_data1 got %h exp 0", {addr1, wr1, errc1, eaddr1, eexp1, egot1}); end
    start0 = 1'b0; start1 = 1'b0; rst = 1'b0;
  endtask

  task automatic test_ideal;
    int nw, nr; bit fin;
    wra0 = 1'b0; rdm0 = 2'd3; ready0 = 1'b1;
    run0(-1, nw, nr, fin);
    checks++; if (!fin) begin errors++; $display("FAIL ideal_finish got 0 exp 1"); end
    checks++; if (nw !== 16 || nr !== 63) begin errors++; $display("FAIL ideal_counts got w=%0d r=%0d exp w=16 r=63", nw, nr); end
    checks++; if ({done0, pass0, to0, errc0} !== {3'b110, 8'd0}) begin errors++; $display("FAIL ideal_status got %b/%0d exp 110/0", {done0, pass0, to0}, errc0); end
    checks++; if ({mem0[5], mem0[4]} !== 16'h5F5E) begin errors++; $display("FAIL ideal_word4 got %h exp 5F5E", {mem0[5], mem0[4]}); end
    checks++; if ({mem0[1], mem0[0]} !== 16'h5B5A) begin errors++; $display("FAIL ideal_word0 got %h exp 5B5A", {mem0[1], mem0[0]}); end
    repeat (5) @(negedge clk);
    checks++; if ({done0, busy0, we0, byte0, addr0} !== {4'b1010, 20'h0}) begin errors++; $display("FAIL ideal_hold got %b %h exp 1010 0", {done0, busy0, we0, byte0}, addr0); end
  endtask

  task automatic test_corrupt;
    int nw, nr; bit fin;
    c13 = 1'b1; wra0 = 1'b1; rdm0 = 2'd0;
    run0(-1, nw, nr, fin);
    checks++; if (!fin || nw !== 17 || nr !== 32) begin errors++; $display("FAIL corrupt_counts got fin=%0d w=%0d r=%0d exp 1/17/32", fin, nw, nr); end
    checks++; if (errc0 !== 8'd1) begin errors++; $display("FAIL corrupt_count got %0d exp 1", errc0); end
    checks++; if (eaddr0 !== 20'h00013 || eexp0 !== 16'h0049 || egot0 !== 16'h0000) begin errors++; $display("FAIL corrupt_latch got %h/%h/%h exp 00013/0049/0000", eaddr0, eexp0, egot0); end
    checks++; if ({done0, pass0} !== 2'b10) begin errors++; $display("FAIL corrupt_flags got %b exp 10", {done0, pass0}); end
    c13 = 1'b0;
  endtask

  task automatic test_timeout;
    int n, k;
    wra0 = 1'b0; rdm0 = 2'd0; ready0 = 1'b1;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    n = 0;
    for (int i = 0; i < 50 && n < 5; i++) begin
      if (busy0 && ready0) n++;
      if (n < 5) @(negedge clk);
    end
    @(posedge clk); #1 ready0 = 1'b0;
    checks++; if (n !== 5 || !busy0 || to0) begin errors++; $display("FAIL timeout_setup got n=%0d busy=%b to=%b exp 5/1/0", n, busy0, to0); end
    k = 0;
    while (!to0 && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    checks++; if (k !== 255) begin errors++; $display("FAIL timeout_cycles got %0d exp 255", k); end
    checks++; if ({to0, done0, pass0, we0, busy0} !== 5'b11010) begin errors++; $display("FAIL timeout_flags got %b exp 11010", {to0, done0, pass0, we0, busy0}); end
    ready0 = 1'b1;
  endtask

  task automatic test_reset_mid;
    int nw, nr, nbad; bit fin;
    wra0 = 1'b0; rdm0 = 2'd3; ready0 = 1'b1;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    for (int i = 0; i < 100 && !(busy0 && we0); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++; if (!(busy0 && we0)) begin errors++; $display("FAIL midrst_in_read got busy=%b we=%b exp 1/1", busy0, we0); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({busy0, done0, pass0, to0, we0, byte0} !== 6'b000010 || {addr0, wr0, errc0, eaddr0, eexp0, egot0} !== '0) begin errors++; $display("FAIL midrst_outputs got %b %h exp 000010 0", {busy0, done0, pass0, to0, we0, byte0}, {addr0, wr0, errc0, eaddr0, eexp0, egot0}); end
    @(negedge clk) rst = 1'b0;
    nbad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy0 || done0 || !we0 || addr0 != 20'h0) nbad++;
    end
    checks++; if (nbad !== 0) begin errors++; $display("FAIL midrst_quiet got %0d exp 0", nbad); end
    wra0 = 1'b0; rdm0 = 2'd1;
    run0(5, nw, nr, fin);
    checks++; if (!fin || nw !== 16 || nr !== 16) begin errors++; $display("FAIL busy_start_counts got fin=%0d w=%0d r=%0d exp 1/16/16", fin, nw, nr); end
    checks++; if ({done0, pass0, errc0} !== {2'b11, 8'd0}) begin errors++; $display("FAIL busy_start_status got %b/%0d exp 11/0", {done0, pass0}, errc0); end
  endtask

  task automatic test_back_to_back;
    int bw, br; bit fin;
    stuck1 = 1'b0; wra1 = 1'b1; rdm1 = 2'd3;
    bw = aw1; br = ar1;
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    checks++; if ({addr1, wr1, we1, byte1} !== {20'h003F8, 16'h00A1, 1'b0, 1'b1}) begin errors++; $display("FAIL slow_req1 got %h %h %b%b exp 003F8 00A1 01", addr1, wr1, we1, byte1); end
    for (int i = 0; i < 10 && !ready1; i++) @(negedge clk);
    @(negedge clk);
    checks++; if ({addr1, wr1, we1, byte1} !== {20'h003F9, 16'hA3A0, 1'b0, 1'b0}) begin errors++; $display("FAIL slow_req2 got %h %h %b%b exp 003F9 A3A0 00", addr1, wr1, we1, byte1); end
    wait_done1(fin);
    checks++; if (!fin || aw1 - bw !== 513 || ar1 - br !== 2047) begin errors++; $display("FAIL slow_counts got fin=%0d w=%0d r=%0d exp 1/513/2047", fin, aw1 - bw, ar1 - br); end
    checks++; if ({done1, pass1, to1, errc1} !== {3'b110, 8'd0}) begin errors++; $display("FAIL slow_status got %b/%0d exp 110/0", {done1, pass1, to1}, errc1); end
    checks++; if ({mem1[12'h400], mem1[12'h3FF]} !== 16'h5EA6 || mem1[12'h3F8] !== 8'hA1) begin errors++; $display("FAIL slow_mem got %h %h exp 5EA6 A1", {mem1[12'h400], mem1[12'h3FF]}, mem1[12'h3F8]); end
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL slow_stable got %0d exp 0", stab_err); end
  endtask

  task automatic test_saturate;
    bit fin;
    stuck1 = 1'b1; wra1 = 1'b0; rdm1 = 2'd0;
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    wait_done1(fin);
    checks++; if (!fin || errc1 !== 8'd255) begin errors++; $display("FAIL sat_count got fin=%0d n=%0d exp 1/255", fin, errc1); end
    checks++; if (eaddr1 !== 20'h003F8 || eexp1 !== 16'h00A1 || egot1 !== 16'h0000) begin errors++; $display("FAIL sat_latch got %h/%h/%h exp 003F8/00A1/0000", eaddr1, eexp1, egot1); end
    checks++; if ({done1, pass1} !== 2'b10) begin errors++; $display("FAIL sat_flags got %b exp 10", {done1, pass1}); end
    stuck1 = 1'b0;
  endtask

  initial begin
    wra0 = 1'b0; wra1 = 1'b0; rdm0 = 2'd0; rdm1 = 2'd0;
    ready0 = 1'b1; c13 = 1'b0; stuck1 = 1'b0;
    test_reset;
    test_ideal;
    test_corrupt;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    test_saturate;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
